// File: rtl/tea_core.sv
// Iterative TEA cipher engine: one full Feistel cycle per clock, either direction
// selected per operation by the latched mode bit.
module tea_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [63:0]  v_in,
    output logic         busy,
    output logic         done,
    output logic [63:0]  v_out
);

    localparam int unsigned CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);
    localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic           mode_q;
    logic [127:0]   key_q;
    logic [31:0]    v0_q, v1_q, sum_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q;
    logic [63:0]    v_out_q;

    logic [31:0]    v0_d, v1_d, sum_d;
    logic [31:0]    k0, k1, k2, k3;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    function automatic logic [31:0] f_mix(input logic [31:0] x, input logic [31:0] s,
                                          input logic [31:0] ka, input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // NOTE: blocking assignments here on purpose -- the second half-round reads
    // the first half-round's result within the same cycle.
    always_comb begin
        sum_d = sum_q;
        v0_d  = v0_q;
        v1_d  = v1_q;
        if (!mode_q) begin
            sum_d = sum_q + DELTA;
            v0_d  = v0_q + f_mix(v1_q, sum_d, k0, k1);
            v1_d  = v1_q + f_mix(v0_d, sum_d, k2, k3);
        end else begin
            v1_d  = v1_q - f_mix(v0_q, sum_q, k2, k3);
            v0_d  = v0_q - f_mix(v1_d, sum_q, k0, k1);
            sum_d = sum_q - DELTA;
        end
    end

    // NOTE: state uses non-blocking assignments only; every register, including
    // the latched key and datapath, is cleared so a reset leaves no stale result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            key_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            v_out_q <= '0;
        end else begin
            // Outputs are registered copies of the state, one cycle behind it.
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        key_q   <= key;
                        v0_q    <= v_in[63:32];
                        v1_q    <= v_in[31:0];
                        sum_q   <= mode ? SUM_DEC : 32'h0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    v0_q  <= v0_d;
                    v1_q  <= v1_d;
                    sum_q <= sum_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        v_out_q <= {v0_d, v1_d};
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign v_out = v_out_q;

endmodule

// File: tb/tb_tea_core.sv
// Scoreboard bench for tea_core: a 32-round and a 1-round instance checked against
// a loop-based TEA reference model, including result timing.
module tb_tea_core;

    localparam int          R_A   = 32;
    localparam int          R_B   = 1;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    typedef struct {
        logic [63:0] v;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_a, start_a, mode_a, busy_a, done_a;
    logic [127:0] key_a;
    logic [63:0]  vin_a, vout_a;
    logic         reset_b, start_b, mode_b, busy_b, done_b;
    logic [127:0] key_b;
    logic [63:0]  vin_b, vout_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   busy_cnt_a = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tea_core #(.ROUNDS(R_A)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .mode(mode_a), .key(key_a),
        .v_in(vin_a), .busy(busy_a), .done(done_a), .v_out(vout_a)
    );

    tea_core #(.ROUNDS(R_B)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .mode(mode_b), .key(key_b),
        .v_in(vin_b), .busy(busy_b), .done(done_b), .v_out(vout_b)
    );

    // Textbook TEA: loop over the rounds with a running sum.
    function automatic logic [63:0] tea_ref(input logic [63:0] v, input logic [127:0] k,
                                            input bit dec, input int rounds);
        logic [31:0] y, z, sum, dec_sum;
        y = v[63:32];
        z = v[31:0];
        dec_sum = 32'h0;
        for (int i = 0; i < rounds; i++) dec_sum += DELTA;
        if (!dec) begin
            sum = 32'h0;
            for (int i = 0; i < rounds; i++) begin
                sum += DELTA;
                y += ((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]);
                z += ((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]);
            end
        end else begin
            sum = dec_sum;
            for (int i = 0; i < rounds; i++) begin
                z -= ((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]);
                y -= ((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]);
                sum -= DELTA;
            end
        end
        return {y, z};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop an expectation whenever a done pulse is seen.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_spurious_done", 64'(done_a), 64'd0);
            end else begin
                e = exp_a.pop_front();
                check("a_v_out", vout_a, e.v);
                check("a_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (busy_a === 1'b1) busy_cnt_a++;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_spurious_done", 64'(done_b), 64'd0);
            end else begin
                e = exp_b.pop_front();
                check("b_v_out", vout_b, e.v);
                check("b_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at 1 time unit after a rising edge with the target engine idle.
    task automatic issue(input bit on_b, input bit m, input logic [127:0] k,
                         input logic [63:0] v, input logic [63:0] expv);
        exp_t e;
        if (on_b) begin
            start_b = 1'b1; mode_b = m; key_b = k; vin_b = v;
        end else begin
            start_a = 1'b1; mode_a = m; key_a = k; vin_a = v;
        end
        @(posedge clk);
        #1;
        e.v = expv;
        if (on_b) begin
            start_b = 1'b0;
            e.cyc = cyc + R_B + 1;
            exp_b.push_back(e);
        end else begin
            start_a = 1'b0;
            e.cyc = cyc + R_A + 1;
            exp_a.push_back(e);
        end
    endtask

    task automatic drain(input bit on_b, input int budget);
        int n = 0;
        while ((on_b ? exp_b.size() : exp_a.size()) != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (on_b) begin
            check("b_drain_pending", 64'(exp_b.size()), 64'd0);
            exp_b.delete();
        end else begin
            check("a_drain_pending", 64'(exp_a.size()), 64'd0);
            exp_a.delete();
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [127:0] k;
        logic [63:0]  v, c;

        reset_a = 1'b1; start_a = 1'b0; mode_a = 1'b0; key_a = '0; vin_a = '0;
        reset_b = 1'b1; start_b = 1'b0; mode_b = 1'b0; key_b = '0; vin_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Idle after reset: nothing moves without start.
        repeat (10) begin
            @(negedge clk);
            check("a_idle_busy", 64'(busy_a), 64'd0);
            check("a_idle_done", 64'(done_a), 64'd0);
            check("a_idle_v_out", vout_a, 64'd0);
            check("b_idle_busy", 64'(busy_b), 64'd0);
        end
        @(posedge clk);
        #1;

        // Known-answer encrypt and decrypt, plus busy duration.
        busy_cnt_a = 0;
        issue(1'b0, 1'b0, 128'd0, 64'd0, 64'h41EA3A0A_94BAA940);
        drain(1'b0, 100);
        check("a_busy_cycles", 64'(busy_cnt_a), 64'(R_A + 1));
        issue(1'b0, 1'b1, 128'd0, 64'h41EA3A0A_94BAA940, 64'd0);
        drain(1'b0, 100);

        // Back-to-back encrypt/decrypt round trips at the first idle cycle.
        for (int i = 0; i < 200; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            v = {$urandom(), $urandom()};
            c = tea_ref(v, k, 1'b0, R_A);
            issue(1'b0, 1'b0, k, v, c);
            repeat (R_A + 1) @(posedge clk);
            #1;
            issue(1'b0, 1'b1, k, c, v);
            repeat (R_A + 1) @(posedge clk);
            #1;
        end
        drain(1'b0, 200);

        // Inputs toggled while busy must not disturb the running operation.
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        v = {$urandom(), $urandom()};
        issue(1'b0, 1'b0, k, v, tea_ref(v, k, 1'b0, R_A));
        repeat (4) @(posedge clk);
        #1;
        start_a = 1'b1; mode_a = 1'b1; key_a = ~k; vin_a = ~v;
        repeat (5) @(posedge clk);
        #1;
        start_a = 1'b0;
        drain(1'b0, 100);

        // Reset in RUN cycle 10 abandons the operation silently.
        start_a = 1'b1; mode_a = 1'b0; key_a = k; vin_a = v;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        @(negedge clk);
        check("a_rst_busy", 64'(busy_a), 64'd0);
        check("a_rst_done", 64'(done_a), 64'd0);
        check("a_rst_v_out", vout_a, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        v = {$urandom(), $urandom()};
        issue(1'b0, 1'b1, k, v, tea_ref(v, k, 1'b1, R_A));
        drain(1'b0, 100);

        // Single-round build: known zero vector, its inverse, then random trips.
        c = tea_ref(64'd0, 128'd0, 1'b0, R_B);
        issue(1'b1, 1'b0, 128'd0, 64'd0, c);
        drain(1'b1, 20);
        issue(1'b1, 1'b1, 128'd0, c, 64'd0);
        drain(1'b1, 20);
        for (int i = 0; i < 20; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            v = {$urandom(), $urandom()};
            c = tea_ref(v, k, 1'b0, R_B);
            issue(1'b1, 1'b0, k, v, c);
            repeat (R_B + 1) @(posedge clk);
            #1;
            issue(1'b1, 1'b1, k, c, v);
            repeat (R_B + 1) @(posedge clk);
            #1;
        end
        drain(1'b1, 20);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
